// File: rtl/periph_timer.sv
// Memory-mapped down-counting timer with prescaler, auto-reload,
// a sticky expiry flag and a free-running cycle counter.
module periph_timer #(
  parameter int INT_LINE = 0,
  parameter int PRESC_W  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [5:0]  int_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic               auto_q, ie_q;
  logic               exp_q, exp_d, exp_set;
  logic [31:0]        load_q, cycle_q;
  logic [31:0]        count_q, count_d;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [2:0]         off;
  logic               wr_ctrl, wr_load, wr_stat, wr_presc;
  logic               tick;
  logic               unused;

  assign off      = addr_i[4:2];
  assign unused   = ^{addr_i[31:5], addr_i[1:0]};
  assign wr_ctrl  = we_i && (off == 3'd0);
  assign wr_load  = we_i && (off == 3'd1);
  assign wr_stat  = we_i && (off == 3'd3);
  assign wr_presc = we_i && (off == 3'd4);
  assign tick     = (state_q == RUN) && (pcnt_q == presc_q);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pcnt_d  = pcnt_q;
    exp_set = 1'b0;
    if (state_q == RUN) begin
      pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
      if (tick) begin
        if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          exp_set = 1'b1;
          if (auto_q) begin
            count_d = load_q;
          end else begin
            count_d = '0;
            state_d = DONE;
          end
        end
      end
    end
    // CTRL writes override the tick; a stop freezes count and prescaler.
    if (wr_ctrl) begin
      if (data_i[0]) begin
        state_d = RUN;
        count_d = load_q;
        pcnt_d  = '0;
      end else begin
        state_d = IDLE;
        count_d = count_q;
        pcnt_d  = pcnt_q;
      end
    end
    exp_d = exp_set | (exp_q & ~(wr_stat & data_i[0]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      auto_q  <= 1'b0;
      ie_q    <= 1'b0;
      exp_q   <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
      exp_q   <= exp_d;
      cycle_q <= cycle_q + 32'd1;
      if (wr_ctrl) begin
        auto_q <= data_i[1];
        ie_q   <= data_i[2];
      end
      if (wr_load) begin
        load_q <= data_i;
      end
      if (wr_presc) begin
        presc_q <= data_i[PRESC_W-1:0];
      end
    end
  end

  always_comb begin
    data_o = '0;
    unique case (off)
      3'd0: data_o = {29'd0, ie_q, auto_q, state_q == RUN};
      3'd1: data_o = load_q;
      3'd2: data_o = count_q;
      3'd3: data_o = {31'd0, exp_q};
      3'd4: data_o[PRESC_W-1:0] = presc_q;
      3'd5: data_o = cycle_q;
      default: data_o = '0;
    endcase
  end

  always_comb begin
    int_o = '0;
    int_o[INT_LINE] = exp_q & ie_q;
  end

endmodule

// File: tb/tb_periph_timer.sv
// Directed bench for periph_timer: reset, one-shot, auto-reload,
// stop/resume, mid-run reset, LOAD=0 and read-only offsets.
`timescale 1ns/1ps
module tb_periph_timer;

  localparam logic [2:0] O_CTRL  = 3'd0;
  localparam logic [2:0] O_LOAD  = 3'd1;
  localparam logic [2:0] O_COUNT = 3'd2;
  localparam logic [2:0] O_STAT  = 3'd3;
  localparam logic [2:0] O_PRESC = 3'd4;
  localparam logic [2:0] O_CYCLE = 3'd5;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [5:0]  int_o;

  int          vec;
  int          miss;
  logic [31:0] v;
  logic [31:0] want;

  periph_timer #(.INT_LINE(0), .PRESC_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .we_i   (we_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .int_o  (int_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] o, input logic [31:0] d);
    @(negedge clk);
    we_i   = 1'b1;
    addr_i = {27'd0, o, 2'b00};
    data_i = d;
    @(posedge clk);
    #1;
    we_i   = 1'b0;
    data_i = '0;
  endtask

  task automatic rd(input logic [2:0] o, output logic [31:0] r);
    addr_i = {27'd0, o, 2'b00};
    #1;
    r = data_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      vec++;
      if (v !== 32'd0) begin
        miss++;
        $display("FAIL reset_off%0d: got %h want 0", i, v);
      end
    end
    vec++;
    if (int_o !== 6'b0) begin
      miss++;
      $display("FAIL reset_int: got %b want 000000", int_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_oneshot();
    wr(O_LOAD, 32'd5);
    wr(O_PRESC, 32'd0);
    wr(O_CTRL, 32'h5);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      rd(O_COUNT, v);
      want = 32'd5 - 32'(i);
      vec++;
      if (v !== want) begin
        miss++;
        $display("FAIL os_count%0d: got %0d want %0d", i, v, want);
      end
    end
    step();
    rd(O_COUNT, v);
    vec++;
    if (v !== 32'd0) begin
      miss++;
      $display("FAIL os_count_exp: got %0d want 0", v);
    end
    rd(O_STAT, v);
    vec++;
    if (v !== 32'd1) begin
      miss++;
      $display("FAIL os_exp: got %h want 1", v);
    end
    rd(O_CTRL, v);
    vec++;
    if (v !== 32'h4) begin
      miss++;
      $display("FAIL os_ctrl: got %h want 4", v);
    end
    vec++;
    if (int_o !== 6'b000001) begin
      miss++;
      $display("FAIL os_int: got %b want 000001", int_o);
    end
    wr(O_STAT, 32'd1);
    vec++;
    if (int_o !== 6'b0) begin
      miss++;
      $display("FAIL os_int_clr: got %b want 000000", int_o);
    end
  endtask

  task automatic test_auto();
    wr(O_LOAD, 32'd3);
    wr(O_PRESC, 32'd2);
    wr(O_CTRL, 32'h3);
    for (int k = 1; k <= 9; k++) begin
      step();
      rd(O_COUNT, v);
      want = (k < 3) ? 32'd3 : (k < 6) ? 32'd2 : (k < 9) ? 32'd1 : 32'd3;
      vec++;
      if (v !== want) begin
        miss++;
        $display("FAIL auto_count%0d: got %0d want %0d", k, v, want);
      end
      rd(O_STAT, v);
      want = (k == 9) ? 32'd1 : 32'd0;
      vec++;
      if (v !== want) begin
        miss++;
        $display("FAIL auto_exp%0d: got %0d want %0d", k, v, want);
      end
    end
    vec++;
    if (int_o !== 6'b0) begin
      miss++;
      $display("FAIL auto_int_masked: got %b want 000000", int_o);
    end
    wr(O_STAT, 32'd1);
    rd(O_STAT, v);
    vec++;
    if (v !== 32'd0) begin
      miss++;
      $display("FAIL auto_clr: got %0d want 0", v);
    end
    for (int k = 0; k < 7; k++) step();
    rd(O_STAT, v);
    vec++;
    if (v !== 32'd0) begin
      miss++;
      $display("FAIL auto_pre_exp2: got %0d want 0", v);
    end
    wr(O_STAT, 32'd1);
    rd(O_STAT, v);
    vec++;
    if (v !== 32'd1) begin
      miss++;
      $display("FAIL auto_set_wins: got %0d want 1", v);
    end
    rd(O_COUNT, v);
    vec++;
    if (v !== 32'd3) begin
      miss++;
      $display("FAIL auto_reload2: got %0d want 3", v);
    end
  endtask

  task automatic test_stop_resume();
    wr(O_CTRL, 32'h0);
    wr(O_STAT, 32'd1);
    wr(O_PRESC, 32'd0);
    wr(O_LOAD, 32'd10);
    wr(O_CTRL, 32'h1);
    step();
    step();
    step();
    rd(O_COUNT, v);
    vec++;
    if (v !== 32'd7) begin
      miss++;
      $display("FAIL stop_pre: got %0d want 7", v);
    end
    wr(O_CTRL, 32'h0);
    for (int k = 0; k < 10; k++) begin
      rd(O_COUNT, v);
      vec++;
      if (v !== 32'd7) begin
        miss++;
        $display("FAIL stop_hold%0d: got %0d want 7", k, v);
      end
      step();
    end
    wr(O_CTRL, 32'h1);
    rd(O_COUNT, v);
    vec++;
    if (v !== 32'd10) begin
      miss++;
      $display("FAIL resume_reload: got %0d want 10", v);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) step();
    rd(O_COUNT, v);
    vec++;
    if (v !== 32'd2) begin
      miss++;
      $display("FAIL rmid_pre: got %0d want 2", v);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    rd(O_COUNT, v);
    vec++;
    if (v !== 32'd0) begin
      miss++;
      $display("FAIL rmid_count: got %0d want 0", v);
    end
    rd(O_CYCLE, v);
    vec++;
    if (v !== 32'd0) begin
      miss++;
      $display("FAIL rmid_cycle: got %0d want 0", v);
    end
    rd(O_CTRL, v);
    vec++;
    if (v !== 32'd0) begin
      miss++;
      $display("FAIL rmid_ctrl: got %h want 0", v);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) step();
    rd(O_STAT, v);
    vec++;
    if (v !== 32'd0 || int_o !== 6'b0) begin
      miss++;
      $display("FAIL rmid_noexp: got stat %0d int %b want 0", v, int_o);
    end
    rd(O_CYCLE, v);
    vec++;
    if (v !== 32'd20) begin
      miss++;
      $display("FAIL rmid_cycle20: got %0d want 20", v);
    end
  endtask

  task automatic test_load_zero();
    wr(O_CTRL, 32'h5);
    rd(O_STAT, v);
    vec++;
    if (v !== 32'd0) begin
      miss++;
      $display("FAIL lz_start: got %0d want 0", v);
    end
    step();
    rd(O_STAT, v);
    vec++;
    if (v !== 32'd1 || int_o !== 6'b000001) begin
      miss++;
      $display("FAIL lz_exp: got stat %0d int %b want 1 000001", v, int_o);
    end
    wr(O_CTRL, 32'h0);
    vec++;
    if (int_o !== 6'b0) begin
      miss++;
      $display("FAIL lz_ie_mask: got %b want 000000", int_o);
    end
    rd(O_STAT, v);
    vec++;
    if (v !== 32'd1) begin
      miss++;
      $display("FAIL lz_exp_kept: got %0d want 1", v);
    end
  endtask

  task automatic test_readonly();
    wr(O_COUNT, 32'h55);
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    wr(O_PRESC, 32'hFFFF_1234);
    rd(O_COUNT, v);
    vec++;
    if (v !== 32'd0) begin
      miss++;
      $display("FAIL ro_count: got %h want 0", v);
    end
    rd(3'd6, v);
    vec++;
    if (v !== 32'd0) begin
      miss++;
      $display("FAIL ro_off6: got %h want 0", v);
    end
    rd(3'd7, v);
    vec++;
    if (v !== 32'd0) begin
      miss++;
      $display("FAIL ro_off7: got %h want 0", v);
    end
    rd(O_PRESC, v);
    vec++;
    if (v !== 32'h0000_1234) begin
      miss++;
      $display("FAIL ro_presc: got %h want 00001234", v);
    end
  endtask

  initial begin
    vec    = 0;
    miss   = 0;
    rst    = 1'b1;
    we_i   = 1'b0;
    addr_i = '0;
    data_i = '0;
    test_reset();
    test_oneshot();
    test_auto();
    test_stop_resume();
    test_reset_mid();
    test_load_zero();
    test_readonly();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
